// File: rtl/ftdi_pkg.sv
// ftdi_pkg: types and pin-level constants shared by the FT232H 245-mode
// synchronous FIFO engines (transmit and receive).
//   tx_state_t    - transmit engine state
//   FTDI_ASSERT   - level of an asserted active-low FTDI strobe
//   FTDI_DEASSERT - level of a released active-low FTDI strobe
//   ftdi_level()  - maps a logical "active" flag onto the pin level
package ftdi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2,
    SIWU  = 2'd3
  } tx_state_t;

  localparam logic FTDI_ASSERT   = 1'b0;
  localparam logic FTDI_DEASSERT = 1'b1;

  function automatic logic ftdi_level(input logic active);
    return active ? FTDI_ASSERT : FTDI_DEASSERT;
  endfunction

endpackage

// File: rtl/ftdi_tx_engine_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   ftdiclk, reset   - clock, synchronous active-high reset (empties the FIFO)
//   push, push_data  - write port; ignored while full
//   pop              - advance the head; ignored while empty
//   head             - current head (valid while !empty)
//   head_next        - what head will be after this edge's push/pop
//   full, empty      - status from the registered pointers
//   count            - number of stored entries
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     ftdiclk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      rd_ptr_next;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign rd_ptr_next = pop_ok ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
  assign head        = mem[rd_ptr_reg[AW-1:0]];
  // If the new head is the slot being written this edge, the RAM does not
  // hold it yet, so bypass the incoming word.
  assign head_next   = (push_ok && (rd_ptr_next == wr_ptr_reg)) ?
                       push_data : mem[rd_ptr_next[AW-1:0]];

  always_ff @(posedge ftdiclk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge ftdiclk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      rd_ptr_reg <= rd_ptr_next;
    end
  end

endmodule

// File: rtl/ftdi_tx_engine.sv
// ftdi_tx_engine: FT232H 245 synchronous FIFO transmit engine (ftdiclk domain).
//   s_data/s_valid/s_ready - upstream byte stream, push on s_valid && s_ready
//   s_flush                - request a SIWU# pulse after bytes pushed so far
//   ftdi_txe_n             - FTDI has room (active low)
//   ftdi_wr_n, ftdi_siwu_n - registered strobes to the FTDI
//   ftdi_rd_n, ftdi_oe_n   - receive path held idle
//   ftdi_data_out          - registered byte to the FTDI
//   ftdi_data_oe           - enable for the board-level tristate
//   bytes_sent             - bytes accepted by the FTDI (wrapping)
//   busy                   - work queued, in flight or flush outstanding
module ftdi_tx_engine
  import ftdi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        ftdiclk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_flush,
  input  logic        ftdi_txe_n,
  output logic        ftdi_wr_n,
  output logic        ftdi_siwu_n,
  output logic        ftdi_rd_n,
  output logic        ftdi_oe_n,
  output logic [7:0]  ftdi_data_out,
  output logic        ftdi_data_oe,
  output logic [31:0] bytes_sent,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_t       state_reg;
  tx_state_t       state_next;
  logic            wr_n_reg;
  logic            wr_n_next;
  logic            siwu_n_reg;
  logic            siwu_n_next;
  logic [7:0]      data_out_reg;
  logic [7:0]      data_out_next;
  logic            flush_pending_reg;
  logic            flush_pending_next;
  logic [31:0]     bytes_sent_reg;
  logic            out_en_reg;

  logic            acc;
  logic            push;
  logic            not_empty_next;
  logic [7:0]      fifo_head;
  logic [7:0]      fifo_head_next;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  // The FTDI takes a byte on the same edge we see WR# and TXE# both low.
  assign acc     = (wr_n_reg == FTDI_ASSERT) && (ftdi_txe_n == FTDI_ASSERT);
  assign s_ready = out_en_reg && !fifo_full;
  assign push    = s_valid && s_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ftdiclk   (ftdiclk),
    .reset     (reset),
    .push      (push),
    .push_data (s_data),
    .pop       (acc),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Occupancy after this edge, including the same-edge push and pop.
  assign not_empty_next = fifo_empty ? push
                                     : !((fifo_count == CW'(1)) && acc && !push);

  // Without a pop the head is unchanged; otherwise take the post-update head.
  assign data_out_next = (acc || fifo_empty) ? fifo_head_next : fifo_head;

  // State register.
  always_ff @(posedge ftdiclk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state. Data always wins over a pending flush; SIWU is only entered
  // from IDLE, which guarantees a gap after the last acceptance.
  always_comb begin
    state_next = IDLE;
    if (not_empty_next) begin
      state_next = (ftdi_txe_n == FTDI_ASSERT) ? SEND : STALL;
    end else if ((state_reg == IDLE) && flush_pending_reg) begin
      state_next = SIWU;
    end
  end

  // Output decode of the next state, registered below.
  always_comb begin
    wr_n_next          = ftdi_level(state_next == SEND);
    siwu_n_next        = ftdi_level(state_next == SIWU);
    flush_pending_next = flush_pending_reg || s_flush;
    if (state_next == SIWU) begin
      flush_pending_next = 1'b0;
    end
  end

  always_ff @(posedge ftdiclk) begin
    if (reset) begin
      wr_n_reg          <= FTDI_DEASSERT;
      siwu_n_reg        <= FTDI_DEASSERT;
      data_out_reg      <= 8'h00;
      flush_pending_reg <= 1'b0;
      bytes_sent_reg    <= 32'd0;
      out_en_reg        <= 1'b0;
    end else begin
      wr_n_reg          <= wr_n_next;
      siwu_n_reg        <= siwu_n_next;
      data_out_reg      <= data_out_next;
      flush_pending_reg <= flush_pending_next;
      bytes_sent_reg    <= bytes_sent_reg + {31'd0, acc};
      out_en_reg        <= 1'b1;
    end
  end

  assign ftdi_wr_n     = wr_n_reg;
  assign ftdi_siwu_n   = siwu_n_reg;
  assign ftdi_rd_n     = FTDI_DEASSERT;
  assign ftdi_oe_n     = FTDI_DEASSERT;
  assign ftdi_data_out = data_out_reg;
  assign ftdi_data_oe  = out_en_reg;
  assign bytes_sent    = bytes_sent_reg;
  assign busy          = !fifo_empty || (wr_n_reg == FTDI_ASSERT) ||
                         flush_pending_reg || (state_reg == SIWU);

endmodule

// File: tb/tb_ftdi_tx_engine.sv
// Scoreboard bench for ftdi_tx_engine: pushes record expected bytes in a
// queue, a negedge monitor pops and compares on every FTDI acceptance.
module tb_ftdi_tx_engine;

  logic        ftdiclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_flush = 1'b0;
  logic        ftdi_txe_n = 1'b1;
  logic        ftdi_wr_n;
  logic        ftdi_siwu_n;
  logic        ftdi_rd_n;
  logic        ftdi_oe_n;
  logic [7:0]  ftdi_data_out;
  logic        ftdi_data_oe;
  logic [31:0] bytes_sent;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_count = 0;
  int run_len = 0;
  int max_run = 0;
  int siwu_count = 0;
  int last_acc_cyc = 0;
  int last_siwu_cyc = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  ftdi_tx_engine #(.DEPTH(16)) dut (
    .ftdiclk       (ftdiclk),
    .reset         (reset),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_flush       (s_flush),
    .ftdi_txe_n    (ftdi_txe_n),
    .ftdi_wr_n     (ftdi_wr_n),
    .ftdi_siwu_n   (ftdi_siwu_n),
    .ftdi_rd_n     (ftdi_rd_n),
    .ftdi_oe_n     (ftdi_oe_n),
    .ftdi_data_out (ftdi_data_out),
    .ftdi_data_oe  (ftdi_data_oe),
    .bytes_sent    (bytes_sent),
    .busy          (busy)
  );

  always #5 ftdiclk = ~ftdiclk;

  always @(posedge ftdiclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle, i.e. the values the next rising edge will see.
  always @(negedge ftdiclk) begin
    if (reset) begin
      run_len = 0;
    end else begin
      if (!ftdi_wr_n && !ftdi_txe_n) begin
        acc_count++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        last_acc_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL acc_unexpected: got 0x%02h expected no byte", ftdi_data_out);
        end else begin
          exp_b = sb.pop_front();
          check("acc_data", {24'd0, ftdi_data_out}, {24'd0, exp_b});
          $display("acc cyc=%0d byte=0x%02h expected=0x%02h", cyc, ftdi_data_out, exp_b);
        end
      end else begin
        run_len = 0;
      end
      if (!ftdi_siwu_n) begin
        siwu_count++;
        last_siwu_cyc = cyc;
        check("siwu_wr_high", {31'd0, ftdi_wr_n}, 32'd1);
        $display("siwu cyc=%0d wr_n=%0b", cyc, ftdi_wr_n);
      end
    end
  end

  task automatic tick();
    @(posedge ftdiclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic f, input logic exp_ready);
    s_data  = b;
    s_valid = 1'b1;
    s_flush = f;
    check("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
    if (exp_ready) sb.push_back(b);
    tick();
    s_valid = 1'b0;
    s_flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    check(name, {31'd0, (n < 300)}, 32'd1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    ftdi_txe_n = 1'b1;
    s_valid    = 1'b0;
    s_flush    = 1'b0;
    sb.delete();
    tick();
    tick();
    check("rst_wr_n", {31'd0, ftdi_wr_n}, 32'd1);
    check("rst_siwu_n", {31'd0, ftdi_siwu_n}, 32'd1);
    check("rst_rd_oe_n", {30'd0, ftdi_rd_n, ftdi_oe_n}, 32'd3);
    check("rst_data_out", {24'd0, ftdi_data_out}, 32'd0);
    check("rst_data_oe", {31'd0, ftdi_data_oe}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_bytes_sent", bytes_sent, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_data_oe", {31'd0, ftdi_data_oe}, 32'd1);
    check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    acc_count  = 0;
    max_run    = 0;
    siwu_count = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Streaming 0x00..0x0F with TXE# low.
    do_reset();
    ftdi_txe_n = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b1);
    drain("stream_drain");
    check("stream_bytes_sent", bytes_sent, 32'd16);
    check("stream_run", max_run, 32'd16);

    // Refusal: TXE# rises on the cycle 0x45 is first presented.
    do_reset();
    ftdi_txe_n = 1'b0;
    push(8'h45, 1'b0, 1'b1);
    check("refuse_present_wr", {31'd0, ftdi_wr_n}, 32'd0);
    check("refuse_present_data", {24'd0, ftdi_data_out}, 32'h45);
    ftdi_txe_n = 1'b1;
    push(8'h46, 1'b0, 1'b1);
    check("refuse_wr_high", {31'd0, ftdi_wr_n}, 32'd1);
    check("refuse_not_counted", bytes_sent, 32'd0);
    check("refuse_head_kept", {24'd0, ftdi_data_out}, 32'h45);
    repeat (3) tick();
    check("refuse_hold_wr", {31'd0, ftdi_wr_n}, 32'd1);
    ftdi_txe_n = 1'b0;
    drain("refuse_drain");
    check("refuse_bytes_sent", bytes_sent, 32'd2);
    check("refuse_acc_count", acc_count, 32'd2);

    // Backpressure: 20 attempts into a 16-deep FIFO with TXE# high.
    do_reset();
    for (int i = 0; i < 20; i++) push(8'(8'h80 + i), 1'b0, (i < 16));
    repeat (2) tick();
    check("bp_ready_low", {31'd0, s_ready}, 32'd0);
    check("bp_none_sent", bytes_sent, 32'd0);
    ftdi_txe_n = 1'b0;
    drain("bp_drain");
    check("bp_bytes_sent", bytes_sent, 32'd16);
    check("bp_ready_back", {31'd0, s_ready}, 32'd1);

    // Flush pushed together with 0x41.
    do_reset();
    ftdi_txe_n = 1'b0;
    push(8'h41, 1'b1, 1'b1);
    n = 0;
    while (ftdi_siwu_n && n < 50) begin
      tick();
      n++;
    end
    check("flush_siwu_seen", {31'd0, (n < 50)}, 32'd1);
    check("flush_siwu_wr", {31'd0, ftdi_wr_n}, 32'd1);
    check("flush_byte_first", bytes_sent, 32'd1);
    check("flush_busy_during", {31'd0, busy}, 32'd1);
    tick();
    check("flush_siwu_one", {31'd0, ftdi_siwu_n}, 32'd1);
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    check("flush_pulse_count", siwu_count, 32'd1);
    check("flush_after_acc", {31'd0, (last_siwu_cyc > last_acc_cyc)}, 32'd1);

    // Reset while 8 bytes are queued and WR# is low.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i), 1'b0, 1'b1);
    ftdi_txe_n = 1'b0;
    tick();
    check("mid_wr_low", {31'd0, ftdi_wr_n}, 32'd0);
    reset = 1'b1;
    sb.delete();
    tick();
    check("mid_rst_wr", {31'd0, ftdi_wr_n}, 32'd1);
    check("mid_rst_siwu", {31'd0, ftdi_siwu_n}, 32'd1);
    check("mid_rst_bytes", bytes_sent, 32'd0);
    reset = 1'b0;
    tick();
    acc_count = 0;
    repeat (3) tick();
    check("mid_no_stale", acc_count, 32'd0);
    push(8'h55, 1'b0, 1'b1);
    drain("mid_drain");
    check("mid_bytes_sent", bytes_sent, 32'd1);
    check("mid_acc_count", acc_count, 32'd1);

    // Counter wrap.
    do_reset();
    ftdi_txe_n = 1'b0;
    dut.bytes_sent_reg = 32'hFFFF_FFFF;
    #1;
    check("wrap_preset", bytes_sent, 32'hFFFF_FFFF);
    push(8'h99, 1'b0, 1'b1);
    drain("wrap_drain");
    check("wrap_zero", bytes_sent, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_engine.md
# ftdi_tx_engine

Byte-stream transmit engine for the FT232H in 245 synchronous FIFO mode, running entirely on the 60 MHz `ftdiclk`. It accepts bytes from upstream logic (ADC packetiser, test pattern source) over a valid/ready handshake and buffers them in a small FIFO. It drains the buffer to the FTDI with correct WR#/TXE# qualification: a byte refused because TXE# rose is kept and re-sent. It also issues a SIWU# send-immediate pulse on request. The board top owns the `ftdi_data` tristate and drives it from `ftdi_data_out`/`ftdi_data_oe`.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `ftdiclk`  in  1  60 MHz clock from the FTDI; sole clock of the block.
- `reset`  in  1  reset, synchronous, active-high; clock ftdiclk.
- `s_data`  in  8  upstream byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  FIFO not full; push occurs when `s_valid && s_ready`.
- `s_flush`  in  1  one-cycle request: pulse SIWU# once all bytes pushed up to and including this cycle are accepted.
- `ftdi_txe_n`  in  1  FTDI TX FIFO has space (low).
- `ftdi_wr_n`  out  1  write strobe, registered.
- `ftdi_siwu_n`  out  1  send-immediate, registered.
- `ftdi_rd_n`, `ftdi_oe_n`  out  1 each  held 1, because the receive path is unused.
- `ftdi_data_out`  out  8  byte presented to the FTDI, registered.
- `ftdi_data_oe`  out  1  top-level tristate enable.
- `bytes_sent`  out  32  count of bytes accepted by the FTDI; wraps at 2^32.
- `busy`  out  1  FIFO non-empty, or WR# low, or flush pending.

## Operation
- Acceptance: at each rising edge, `acc = !ftdi_wr_n && !ftdi_txe_n`, using the values present before the edge. This matches the FTDI's own sampling.
  - On `acc`: pop the FIFO head and increment `bytes_sent`.
- WR# and data update at every edge:
  - `ftdi_wr_n <= !(fifo_not_empty_next && !ftdi_txe_n)`, where `fifo_not_empty_next` includes the same-edge push and pop.
  - `ftdi_data_out <=` the head after the update.
- Refusal: if WR# is low and TXE# is high at an edge, no pop occurs and the byte stays at the head. WR# goes high. The byte is re-presented once TXE# is sampled low.
- FIFO behaviour:
  - A push while full is impossible, because `s_ready` is low.
  - Simultaneous push and pop while full is not allowed; `s_ready` reflects the pre-edge count only.
  - A simultaneous push and pop while non-full leaves the count unchanged.
- FSM `tx_state_t`:
  - `IDLE`: FIFO empty, WR# high.
  - `SEND`: FIFO non-empty and TXE# low; WR# low.
  - `STALL`: FIFO non-empty and TXE# high; WR# high.
  - `SIWU`: `ftdi_siwu_n` low for exactly one cycle.
- FSM transitions:
  - Out of `SEND`/`STALL`/`IDLE`, transitions follow the WR# rule above.
  - `IDLE` → `SIWU` when a flush is pending, the FIFO is empty and WR# is high.
  - `SIWU` → `IDLE`, or `SEND` if data arrived during `SIWU` and TXE# is low.
- Flush:
  - `s_flush` sets `flush_pending`. Repeat requests while pending merge into one.
  - A byte pushed in the same cycle as `s_flush` is sent before the SIWU pulse.
  - Bytes pushed after the request delay the pulse until the FIFO drains; this is accepted behaviour.
  - WR# is never low during `SIWU`.
- Reset values: `ftdi_wr_n`=1, `ftdi_siwu_n`=1, `ftdi_rd_n`=1, `ftdi_oe_n`=1, `ftdi_data_out`=0, `ftdi_data_oe`=0, `s_ready`=0, `bytes_sent`=0, `busy`=0, FIFO empty, `flush_pending`=0, state `IDLE`.
- After reset: `ftdi_data_oe`=1 from the first cycle after `reset` deasserts, and `s_ready`=1 from that cycle (the FIFO is empty).
- Reset mid-transfer: the FIFO contents and any pending flush are discarded. WR# is high at the first edge with `reset` high.

## Timing
- Push at edge k with TXE# low: WR# low and data valid after edge k; the FTDI accepts at edge k+1.
  - Minimum latency from push to acceptance is 1 cycle.
- Sustained throughput is 1 byte/cycle while TXE# stays low.
- TXE# rising costs at most one refused strobe. Resume occurs 1 cycle after TXE# is sampled low.
- `s_ready` is combinational from the registered count only; it has no path from `s_valid`.
- The SIWU pulse follows the last acceptance by ≥ 1 cycle.

## Structure
- `ftdi_pkg` holds `tx_state_t` and the FTDI level constants (`FTDI_ASSERT = 1'b0`, `FTDI_DEASSERT = 1'b1`). The receive engine reuses the package.
- Sub-module `sync_fifo`: a single-clock FIFO with parameters `WIDTH`/`DEPTH` and pointers one bit wider than the address. It exposes `full`, `empty`, `count` and a first-word-fall-through head.
- The top-level `ftdi_data` tristate stays outside this block.

## Test plan
- **Streaming:** push 0x00..0x0F with TXE# held low → 16 consecutive WR# low cycles, data in order 0x00..0x0F, `bytes_sent`=16.
- **Refusal:** push 0x45, 0x46 and raise TXE# on the cycle 0x45 is first presented → 0x45 is not counted, WR# goes high. TXE# low 3 cycles later → 0x45 then 0x46 are accepted, `bytes_sent`=2, no duplicates.
- **Backpressure:** TXE# high, push 20 bytes with `DEPTH`=16 → `s_ready` low after 16 pushes and stays low. Release TXE# → all 16 sent in order, then `s_ready`=1.
- **Flush:** push 0x41 together with `s_flush`, TXE# low → 0x41 accepted, then exactly one SIWU# low cycle, WR# high throughout that cycle, `busy` deasserts the next cycle.
- **Reset mid-transfer:** assert `reset` with 8 bytes queued and WR# low → WR# and SIWU# are 1, `bytes_sent`=0. After release, no stale byte is emitted and a new push of 0x55 is the first byte sent.
- **Wrap:** force `bytes_sent` to 0xFFFF_FFFF, then one acceptance → counter reads 0.
